life_engine: RTL and testbench
==============================

LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 The block SHALL use clock clk and reset reset (asynchronous, active-high).
REQ-002 Port list SHALL be:
  clk        input   1   rising-edge clock
  reset      input   1   async active-high reset
  load       input   1   load seed into grid (sampled each edge)
  seed       input   64  initial board; bit 8*r+c = cell row r, col c (1 = alive)
  step       input   1   request one generation (sampled each edge)
  grid       output  64  current board, same bit mapping as seed
  busy       output  1   high while a generation is in progress
  done       output  1   one-cycle pulse: generation committed
  gen_count  output  16  generations since last load

Function
REQ-003 The block SHALL hold an 8x8 board and a 64-bit next-board buffer; grid SHALL always show the committed board only, never partial rows.
REQ-004 The FSM SHALL have three states: IDLE, COMPUTE, COMMIT.
REQ-005 In IDLE with load=1: grid<=seed, gen_count<=0, state stays IDLE.
REQ-006 In IDLE with step=1 and load=0: row counter<=0, state<=COMPUTE.
REQ-007 In IDLE with load=1 and step=1 on the same edge: load wins; step is dropped.
REQ-008 In COMPUTE, each cycle SHALL compute row r of the next board from the committed grid and then increment r; after r=7, state<=COMMIT (exactly 8 COMPUTE cycles).
REQ-009 Cell rule: next=1 if live neighbours = 3, or if cell=1 and live neighbours = 2; otherwise 0. Neighbour count 0..8, at least 4 bits wide.
REQ-010 In COMMIT: grid<=next board, gen_count<=gen_count+1 (wraps 0xFFFF->0x0000), done<=1 for exactly one cycle, state<=IDLE.
REQ-011 Latency: step sampled at edge k -> grid and done updated at edge k+9; a new step is accepted from edge k+10 on.
REQ-012 busy SHALL be 1 in COMPUTE and COMMIT, 0 in IDLE.
REQ-013 step while busy SHALL be ignored (not queued).
REQ-014 load while busy SHALL abort the generation: grid<=seed, gen_count<=0, state<=IDLE, no done pulse, the partial next board discarded.
REQ-015 Edge cells SHALL treat out-of-board neighbours per REQ-019.

Reset
REQ-016 On reset: state=IDLE, grid=0, next buffer=0, row counter=0, gen_count=0, busy=0, done=0.
REQ-017 Reset mid-generation SHALL abandon the generation immediately, with no done pulse.
REQ-018 The first step after reset SHALL evolve the all-zero board (result all-zero, gen_count=1).

Configuration
REQ-019 With macro LIFE_WRAP_EN defined, the board SHALL be toroidal: row 7 neighbours row 0 and col 7 neighbours col 0. Without it, out-of-board neighbours SHALL count as dead.

Verification
REQ-020 Blinker: load seed=64'h0000_0000_1C00_0000, step -> done at edge k+9, grid=64'h0000_0008_0808_0000; second step -> grid=64'h0000_0000_1C00_0000, gen_count=2.
REQ-021 Still life: load 64'h0000_0018_1800_0000, step three times -> grid unchanged after each step, gen_count=3, busy low between steps.
REQ-022 Edge blinker: load 64'h0000_0000_0000_001C, step -> grid=64'h0800_0000_0000_0808 with LIFE_WRAP_EN; 64'h0000_0000_0000_0808 without it.
REQ-023 Abort: step, then at the 4th COMPUTE cycle load 64'hFFFF_FFFF_FFFF_FFFF -> no done pulse, grid=all-ones, gen_count=0, busy=0 next cycle.
REQ-024 Collisions: load and step on the same edge in IDLE -> grid=seed, busy stays 0; step pulsed while busy -> ignored, exactly one done pulse.
REQ-025 Reset: assert reset during COMPUTE -> grid=0, busy=0, done=0 asynchronously; a following step yields grid=0, gen_count=1.

Source files
------------

// File: rtl/life_engine.sv
// life_engine: 8x8 Conway's Game of Life engine.
// A generation is computed one row per cycle into a shadow buffer and then
// committed to the visible board in a single cycle, so grid never shows a
// half-updated board.
// Optional feature: define LIFE_WRAP_EN for a toroidal board (row 7 touches
// row 0, col 7 touches col 0); otherwise off-board neighbours are dead.
module life_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        step,
    output logic [63:0] grid,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count
);

    localparam int unsigned GRID_W = 64;
    localparam int unsigned GEN_W  = 16;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NROWS  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [GRID_W-1:0]   grid_q,  grid_d;
    logic [GRID_W-1:0]   next_q,  next_d;
    logic [ROW_W-1:0]    row_q,   row_d;
    logic [GEN_W-1:0]    gen_q,   gen_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    logic [NROWS-1:0]    row_next_c;
    logic [CNT_W-1:0]    nbrs;
    logic                cell_alive;

    // Liveness of board cell (r, c); r/c may step one past the board edge.
    function automatic logic alive_at(input logic [GRID_W-1:0] g,
                                      input int r, input int c);
        logic [ROW_W-1:0] rr;
        logic [ROW_W-1:0] cc;
`ifdef LIFE_WRAP_EN
        // Truncating to 3 bits maps -1 to 7 and 8 to 0.
        rr = ROW_W'(r);
        cc = ROW_W'(c);
        return g[{rr, cc}];
`else
        if (r < 0 || r > 7 || c < 0 || c > 7) begin
            return 1'b0;
        end
        rr = ROW_W'(r);
        cc = ROW_W'(c);
        return g[{rr, cc}];
`endif
    endfunction

    // Next-generation value of the row selected by row_q, from the committed board.
    always_comb begin
        row_next_c = '0;
        nbrs       = '0;
        cell_alive = 1'b0;
        for (int c = 0; c < 8; c++) begin
            nbrs = '0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (!(dr == 0 && dc == 0)) begin
                        nbrs = nbrs + CNT_W'(alive_at(grid_q, int'(row_q) + dr, c + dc));
                    end
                end
            end
            cell_alive    = alive_at(grid_q, int'(row_q), c);
            row_next_c[c] = (nbrs == CNT_W'(3)) || (cell_alive && nbrs == CNT_W'(2));
        end
    end

    // Next-state and datapath updates; load always wins and aborts any generation.
    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        next_d  = next_q;
        row_d   = row_q;
        gen_d   = gen_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    grid_d = seed;
                    gen_d  = '0;
                end else if (step) begin
                    row_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (load) begin
                    grid_d  = seed;
                    gen_d   = '0;
                    next_d  = '0;
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    next_d[{row_q, 3'b000} +: NROWS] = row_next_c;
                    row_d = row_q + ROW_W'(1);
                    if (row_q == ROW_W'(7)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (load) begin
                    grid_d  = seed;
                    gen_d   = '0;
                    next_d  = '0;
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    grid_d  = next_q;
                    gen_d   = gen_q + GEN_W'(1);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            next_q  <= '0;
            row_q   <= '0;
            gen_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            next_q  <= next_d;
            row_q   <= row_d;
            gen_q   <= gen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign grid      = grid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// Testbench for life_engine: table of seeds with known next boards, random
// seeds against a reference model, and hand sequences for abort, collisions
// and reset. Expected boards are queued on each accepted step and checked
// when done pulses.
module tb_life_engine;

    logic        clk;
    logic        reset;
    logic        load;
    logic [63:0] seed;
    logic        step;
    logic [63:0] grid;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    life_engine dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .step      (step),
        .grid      (grid),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] grid;
        logic [15:0] gen;
    } exp_t;

    typedef struct {
        logic [63:0] seed;
        logic [63:0] next;
    } vec_t;

    exp_t        sb_q[$];
    int          applied  = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [63:0] model_grid;
    logic [15:0] model_gen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference Life rule, neighbours counted with explicit bounds or modulo wrap.
    function automatic logic [63:0] life_ref(input logic [63:0] g);
        logic [63:0] n;
        int          cnt;
        int          rr;
        int          cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_WRAP_EN
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                            if (g[rr*8+cc]) cnt++;
`else
                            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                                if (g[rr*8+cc]) cnt++;
`endif
                        end
                    end
                end
                n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                applied++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (grid %h)", grid);
            end else begin
                e = sb_q.pop_front();
                check("sb_grid", grid, e.grid);
                check("sb_gen", 64'(gen_count), 64'(e.gen));
            end
        end
    end

    task automatic do_load(input logic [63:0] s);
        @(negedge clk);
        load = 1'b1;
        seed = s;
        @(posedge clk);
        #1 load = 1'b0;
        model_grid = s;
        model_gen  = '0;
        @(negedge clk);
        check("load_grid", grid, s);
        check("load_gen", 64'(gen_count), 64'd0);
    endtask

    task automatic start_step(input logic [63:0] exp_grid);
        exp_t e;
        model_grid = exp_grid;
        model_gen  = model_gen + 16'd1;
        e.grid = exp_grid;
        e.gen  = model_gen;
        sb_q.push_back(e);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    // Waits (bounded) for done; optionally checks latency, busy and board stability.
    task automatic wait_done(input bit chk_lat, input logic [63:0] prev);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (chk_lat && n == 1) check("busy_in_compute", 64'(busy), 64'd1);
            if (chk_lat && n == 5) check("grid_stable_mid", grid, prev);
        end while (!done && n < 30);
        if (!done) begin
            applied++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end else if (chk_lat) begin
            check("latency", 64'(n), 64'd10);
            check("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    task automatic do_step(input logic [63:0] exp_grid);
        logic [63:0] prev;
        prev = model_grid;
        start_step(exp_grid);
        wait_done(1'b1, prev);
    endtask

    vec_t vecs[6];
    int   d0;

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        step  = 1'b0;
        seed  = '0;
        model_grid = '0;
        model_gen  = '0;

        vecs[0] = '{64'h0000_0000_1C00_0000, 64'h0000_0008_0808_0000};
        vecs[1] = '{64'h0000_0018_1800_0000, 64'h0000_0018_1800_0000};
`ifdef LIFE_WRAP_EN
        vecs[2] = '{64'h0000_0000_0000_001C, 64'h0800_0000_0000_0808};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
`else
        vecs[2] = '{64'h0000_0000_0000_001C, 64'h0000_0000_0000_0808};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8100_0000_0000_0081};
`endif
        vecs[4] = '{64'h0000_0000_0010_0000, 64'h0000_0000_0000_0000};
        vecs[5] = '{64'h0000_0000_0000_0303, 64'h0000_0000_0000_0303};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grid", grid, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_gen", 64'(gen_count), 64'd0);
        reset = 1'b0;

        // First step after reset evolves the empty board.
        do_step(64'd0);

        // Table: known next board, then a model-predicted second generation.
        foreach (vecs[i]) begin
            do_load(vecs[i].seed);
            do_step(vecs[i].next);
            do_step(life_ref(model_grid));
        end

        // Still life stays put over three steps.
        do_load(64'h0000_0018_1800_0000);
        for (int i = 0; i < 3; i++) begin
            do_step(64'h0000_0018_1800_0000);
            check("still_busy_low", 64'(busy), 64'd0);
        end
        check("still_gen", 64'(gen_count), 64'd3);

        // Random boards against the reference model.
        for (int i = 0; i < 4; i++) begin
            do_load({$urandom, $urandom});
            do_step(life_ref(model_grid));
            do_step(life_ref(model_grid));
        end

        // Abort: load on the 4th COMPUTE cycle discards the generation.
        do_load(64'h0000_0000_1C00_0000);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (4) @(negedge clk);
        load = 1'b1;
        seed = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1 load = 1'b0;
        model_grid = 64'hFFFF_FFFF_FFFF_FFFF;
        model_gen  = '0;
        d0 = done_cnt;
        @(negedge clk);
        check("abort_grid", grid, 64'hFFFF_FFFF_FFFF_FFFF);
        check("abort_gen", 64'(gen_count), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        do_step(life_ref(model_grid));

        // Load and step on the same edge: load wins, no generation starts.
        @(negedge clk);
        load = 1'b1;
        step = 1'b1;
        seed = 64'h0000_0000_1C00_0000;
        @(posedge clk);
        #1 begin load = 1'b0; step = 1'b0; end
        model_grid = 64'h0000_0000_1C00_0000;
        model_gen  = '0;
        d0 = done_cnt;
        @(negedge clk);
        check("coll_grid", grid, 64'h0000_0000_1C00_0000);
        check("coll_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        check("coll_no_done", 64'(done_cnt - d0), 64'd0);
        check("coll_gen", 64'(gen_count), 64'd0);

        // Step while busy is ignored: exactly one done.
        d0 = done_cnt;
        start_step(life_ref(model_grid));
        repeat (2) @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        wait_done(1'b0, 64'd0);
        repeat (12) @(negedge clk);
        check("busy_step_dones", 64'(done_cnt - d0), 64'd1);
        check("busy_step_gen", 64'(gen_count), 64'd1);

        // Reset mid-COMPUTE clears everything asynchronously.
        do_load(64'h0000_0000_1C00_0000);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        sb_q.delete();
        check("arst_grid", grid, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_gen", 64'(gen_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_grid = '0;
        model_gen  = '0;
        do_step(64'd0);
        check("arst_step_gen", 64'(gen_count), 64'd1);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
